dmem_stall: RTL and testbench

Parametrised data memory for the pipelined RISC-V core, successor to the single-cycle word-only `dmem`. It adds byte/halfword/word loads and stores with sign/zero extension, misalignment detection, and a configurable number of wait states. A `stall` handshake freezes the pipeline while an access is pending. It sits on the MEM stage: address from `ALUresultM`, write data from `writedataM`, access size from `funct3M`.

---
 rtl/mem_pkg.sv | 19 +
 rtl/dmem_stall_if.sv | 16 +
 rtl/dmem_lane.sv | 76 +++++++
 rtl/dmem_stall.sv | 151 +++++++++++++++
 tb/tb_dmem_stall.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory block.
// Contents: access-size encodings, FSM state encoding, and the funct3
// bit position that selects zero-extension on loads.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // funct3[2] set means unsigned (zero-extended) load
    localparam int F3_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_stall_if.sv
// MEM-stage to data-memory bus.
// master (pipeline): drives req, we, a, wd, funct3; receives rd, stall, misaligned.
// slave  (memory)  : the reverse.
interface dmem_stall_if;
    logic        req;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  funct3;
    logic [31:0] rd;
    logic        stall;
    logic        misaligned;

    modport master (output req, we, a, wd, funct3, input rd, stall, misaligned);
    modport slave  (input req, we, a, wd, funct3, output rd, stall, misaligned);
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering for sub-word accesses (purely combinational).
// Inputs : size, uns (zero-extend), off = a[1:0], wd (right-aligned store
//          data), rword (current memory word).
// Outputs: wmask (byte lanes written), wword (rword with store data merged),
//          ldval (extended load value, 0 if misaligned), mis (rejected access).
module dmem_lane
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wword,
    output logic [31:0] ldval,
    output logic        mis
);

    logic [31:0] src_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Alignment check, lane mask and merged write word
    always_comb begin
        mis   = ((size == SZ_H) && off[0]) ||
                ((size == SZ_W) && (off != 2'b00)) ||
                (size == 2'b11);
        wmask = 4'b0000;
        src_s = wd;
        case (size)
            SZ_B: begin
                wmask = 4'b0001 << off;
                src_s = {4{wd[7:0]}};
            end
            SZ_H: begin
                wmask = off[1] ? 4'b1100 : 4'b0011;
                src_s = {2{wd[15:0]}};
            end
            SZ_W: begin
                wmask = 4'b1111;
                src_s = wd;
            end
            default: begin
                wmask = 4'b0000;
                src_s = wd;
            end
        endcase
        if (mis) begin
            wmask = 4'b0000;
        end else begin
            wmask = wmask;
        end
        for (int i = 0; i < 4; i++) begin
            wword[8*i +: 8] = wmask[i] ? src_s[8*i +: 8] : rword[8*i +: 8];
        end
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        byte_s = rword[{off, 3'b000} +: 8];
        half_s = off[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_B:    ldval = uns ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_H:    ldval = uns ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            SZ_W:    ldval = rword;
            default: ldval = 32'd0;
        endcase
        if (mis) begin
            ldval = 32'd0;
        end else begin
            ldval = ldval;
        end
    end

endmodule

// File: rtl/dmem_stall.sv
// Data memory for the pipelined core with byte/half/word accesses and
// WAIT_CYCLES wait states signalled through stall.
// Ports: clock (rising edge), reset (synchronous, active-high),
//        bus (dmem_stall_if.slave: req/we/a/wd/funct3 in, rd/stall/misaligned out).
// Parameters: DEPTH_WORDS (power of two), WAIT_CYCLES (0 = single cycle),
//             INIT_FILE (hex image name).
module dmem_stall
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic          clock,
    input  logic          reset,
    dmem_stall_if.slave   bus
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [31:0]       mem_r [DEPTH_WORDS];
    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              load_s, stall_s;
    logic [ADDR_W+1:0] lat_a_r;
    logic [31:0]       lat_wd_r;
    logic              lat_we_r;
    logic [2:0]        lat_f3_r;

    logic [ADDR_W+1:0] acc_a_s;
    logic [31:0]       acc_wd_s;
    logic              acc_we_s;
    logic [2:0]        acc_f3_s;
    logic              acc_live_s;
    logic [31:0]       rword_s, wword_s, ldval_s;
    logic [3:0]        wmask_s;
    logic              mis_s, wr_en_s;

    // Address bits above the word index alias and are deliberately dropped
    logic unused_addr_s;
    assign unused_addr_s = ^bus.a[31:ADDR_W+2];

    // Pick the access being completed: live bus when zero-wait, latch otherwise
    always_comb begin
        if (WAIT_CYCLES == 0) begin
            acc_a_s    = bus.a[ADDR_W+1:0];
            acc_wd_s   = bus.wd;
            acc_we_s   = bus.we;
            acc_f3_s   = bus.funct3;
            acc_live_s = bus.req;
        end else begin
            acc_a_s    = lat_a_r;
            acc_wd_s   = lat_wd_r;
            acc_we_s   = lat_we_r;
            acc_f3_s   = lat_f3_r;
            acc_live_s = (state_r == ST_DONE);
        end
    end

    assign rword_s = mem_r[acc_a_s[ADDR_W+1:2]];

    dmem_lane u_lane (
        .size  (acc_f3_s[1:0]),
        .uns   (acc_f3_s[F3_UNSIGNED_BIT]),
        .off   (acc_a_s[1:0]),
        .wd    (acc_wd_s),
        .rword (rword_s),
        .wmask (wmask_s),
        .wword (wword_s),
        .ldval (ldval_s),
        .mis   (mis_s)
    );

    // An empty mask already covers misaligned stores; reset discards the commit
    assign wr_en_s        = acc_live_s && acc_we_s && (|wmask_s) && !reset;
    assign bus.rd         = (acc_live_s && !acc_we_s) ? ldval_s : 32'd0;
    assign bus.misaligned = acc_live_s && mis_s;
    assign bus.stall      = stall_s;

    // Next-state, countdown and stall generation
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req && (WAIT_CYCLES > 0)) begin
                    stall_s = 1'b1;
                    load_s  = 1'b1;
                    cnt_s   = CNT_LOAD;
                    // The accepting cycle is itself the first wait state
                    state_s = (WAIT_CYCLES == 1) ? ST_DONE : ST_WAIT;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request latch, captured on acceptance so req may drop afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_a_r  <= {(ADDR_W+2){1'b0}};
            lat_wd_r <= 32'd0;
            lat_we_r <= 1'b0;
            lat_f3_r <= 3'b000;
        end else if (load_s) begin
            lat_a_r  <= bus.a[ADDR_W+1:0];
            lat_wd_r <= bus.wd;
            lat_we_r <= bus.we;
            lat_f3_r <= bus.funct3;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[acc_a_s[ADDR_W+1:2]] <= wword_s;
        end
    end

endmodule

// File: tb/tb_dmem_stall.sv
// Self-checking bench for dmem_stall: three instances (W=0/256 words,
// W=2/256 words, W=3/16 words) exercised through a scoreboard queue.
module tb_dmem_stall;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        chk_rd;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst2 = 1'b1, rst3 = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_stall_if if0();
    dmem_stall_if if2();
    dmem_stall_if if3();

    dmem_stall #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (.clock(clk), .reset(rst0), .bus(if0.slave));
    dmem_stall #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .INIT_FILE("")) dut2 (.clock(clk), .reset(rst2), .bus(if2.slave));
    dmem_stall #(.DEPTH_WORDS(16),  .WAIT_CYCLES(3), .INIT_FILE("")) dut3 (.clock(clk), .reset(rst3), .bus(if3.slave));

    task automatic set_req(input int sel, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3);
        case (sel)
            0: begin if0.req = r; if0.we = w; if0.a = a; if0.wd = d; if0.funct3 = f3; end
            2: begin if2.req = r; if2.we = w; if2.a = a; if2.wd = d; if2.funct3 = f3; end
            3: begin if3.req = r; if3.we = w; if3.a = a; if3.wd = d; if3.funct3 = f3; end
            default: ;
        endcase
    endtask

    // {stall, misaligned, rd}
    function automatic logic [33:0] get_out(input int sel);
        case (sel)
            0:       return {if0.stall, if0.misaligned, if0.rd};
            2:       return {if2.stall, if2.misaligned, if2.rd};
            3:       return {if3.stall, if3.misaligned, if3.rd};
            default: return 34'd0;
        endcase
    endfunction

    // Entered and left at posedge+1; the next call may follow with no bubble.
    task automatic do_access(input int sel, input int w_cycles, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] f3,
                             input logic [31:0] exp_rd, input logic exp_mis, input string name);
        exp_t e;
        exp_t got;
        logic [33:0] o;
        int stalls = 0;
        bit done = 1'b0;
        e.rd = exp_rd; e.mis = exp_mis; e.chk_rd = !w; e.name = name;
        sb.push_back(e);
        set_req(sel, 1'b1, w, a, d, f3);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            o = get_out(sel);
            if (o[33]) begin
                stalls++;
            end else begin
                got = sb.pop_front();
                done = 1'b1;
                if (got.chk_rd) begin
                    checks++;
                    if (o[31:0] !== got.rd) begin
                        failures++;
                        $display("FAIL %s rd: got %h want %h", got.name, o[31:0], got.rd);
                    end
                end
                checks++;
                if (o[32] !== got.mis) begin
                    failures++;
                    $display("FAIL %s misaligned: got %b want %b", got.name, o[32], got.mis);
                end
                checks++;
                if (stalls != w_cycles) begin
                    failures++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", got.name, stalls, w_cycles);
                end
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            failures++;
            void'(sb.pop_front());
            $display("FAIL %s timeout: no completion within 20 cycles", name);
        end
        set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    endtask

    task automatic test_reset();
        logic [33:0] o;
        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_req(2, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        set_req(3, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        o = get_out(0);
        checks++;
        if (o[33:32] !== 2'b00) begin
            failures++;
            $display("FAIL reset_w0 stall/mis: got %b want 00", o[33:32]);
        end
        o = get_out(2);
        checks++;
        if (o !== 34'd0) begin
            failures++;
            $display("FAIL reset_w2 outputs: got %h want 0", o);
        end
        o = get_out(3);
        checks++;
        if (o !== 34'd0) begin
            failures++;
            $display("FAIL reset_w3 outputs: got %h want 0", o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_w0();
        do_access(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0, "w0_sw");
        do_access(0, 0, 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, "w0_lw");
        do_access(0, 0, 1'b1, 32'h11, 32'h000000A5, 3'b000, 32'd0, 1'b0, "w0_sb");
        do_access(0, 0, 1'b0, 32'h10, 32'd0, 3'b010, 32'hDEADA5EF, 1'b0, "w0_lw2");
    endtask

    task automatic test_bytes();
        do_access(2, 2, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0, "b_sw_init");
        do_access(2, 2, 1'b1, 32'h13, 32'h00000080, 3'b000, 32'd0, 1'b0, "b_sb");
        do_access(2, 2, 1'b0, 32'h13, 32'd0, 3'b000, 32'hFFFFFF80, 1'b0, "b_lb");
        do_access(2, 2, 1'b0, 32'h13, 32'd0, 3'b100, 32'h00000080, 1'b0, "b_lbu");
        do_access(2, 2, 1'b0, 32'h10, 32'd0, 3'b010, 32'h80ADBEEF, 1'b0, "b_lw");
    endtask

    task automatic test_half();
        do_access(2, 2, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0, "h_sw_init");
        do_access(2, 2, 1'b1, 32'h12, 32'h00001234, 3'b001, 32'd0, 1'b0, "h_sh");
        do_access(2, 2, 1'b0, 32'h12, 32'd0, 3'b001, 32'h00001234, 1'b0, "h_lh");
        do_access(2, 2, 1'b0, 32'h10, 32'd0, 3'b010, 32'h1234BEEF, 1'b0, "h_lw");
        do_access(2, 2, 1'b0, 32'h10, 32'd0, 3'b001, 32'hFFFFBEEF, 1'b0, "h_lh_neg");
        do_access(2, 2, 1'b0, 32'h10, 32'd0, 3'b101, 32'h0000BEEF, 1'b0, "h_lhu");
    endtask

    task automatic test_misaligned();
        do_access(3, 3, 1'b1, 32'h20, 32'h11223344, 3'b010, 32'd0, 1'b0, "m_sw_init");
        do_access(3, 3, 1'b1, 32'h21, 32'h99999999, 3'b010, 32'd0, 1'b1, "m_sw_odd");
        do_access(3, 3, 1'b0, 32'h20, 32'd0, 3'b010, 32'h11223344, 1'b0, "m_lw_unchanged");
        do_access(3, 3, 1'b1, 32'h23, 32'h0000FFFF, 3'b001, 32'd0, 1'b1, "m_sh_odd");
        do_access(3, 3, 1'b0, 32'h05, 32'd0, 3'b001, 32'd0, 1'b1, "m_lh_odd");
        do_access(3, 3, 1'b0, 32'h20, 32'd0, 3'b011, 32'd0, 1'b1, "m_size11");
        do_access(3, 3, 1'b0, 32'h20, 32'd0, 3'b010, 32'h11223344, 1'b0, "m_lw_final");
    endtask

    task automatic test_reset_mid();
        logic [33:0] o;
        do_access(3, 3, 1'b1, 32'h30, 32'h0BADF00D, 3'b010, 32'd0, 1'b0, "r_sw_old");
        set_req(3, 1'b1, 1'b1, 32'h30, 32'hAAAA5555, 3'b010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst3 = 1'b1;
        set_req(3, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(negedge clk);
        o = get_out(3);
        checks++;
        if (o !== 34'd0) begin
            failures++;
            $display("FAIL r_after_reset outputs: got %h want 0", o);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_access(3, 3, 1'b0, 32'h30, 32'd0, 3'b010, 32'h0BADF00D, 1'b0, "r_lw_old");
    endtask

    task automatic test_back_to_back();
        do_access(3, 3, 1'b1, 32'h40, 32'h00000011, 3'b010, 32'd0, 1'b0, "a_sw_alias");
        do_access(3, 3, 1'b0, 32'h00, 32'd0, 3'b010, 32'h00000011, 1'b0, "a_lw_alias");
        do_access(3, 3, 1'b1, 32'h44, 32'hCAFE0055, 3'b010, 32'd0, 1'b0, "a_sw2");
        do_access(3, 3, 1'b0, 32'h04, 32'd0, 3'b010, 32'hCAFE0055, 1'b0, "a_lw2");
        do_access(3, 3, 1'b0, 32'h47, 32'd0, 3'b000, 32'hFFFFFFCA, 1'b0, "a_lb_alias");
        do_access(2, 2, 1'b0, 32'h412, 32'd0, 3'b101, 32'h00001234, 1'b0, "a_lhu_w2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_w0();
        test_bytes();
        test_half();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
